// File: rtl/rs_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : rs_issue_queue
// Purpose  : Reservation station / issue queue sitting between dispatch and
//            the ALU functional units. Accepts one renamed instruction per
//            cycle, assigns it an FU round-robin, wakes waiting operands from
//            NUM_CDB broadcast buses and issues at most one ready entry per FU
//            per cycle.
// Ports    : clk, reset (async, active-high), flush (sync clear)
//            disp_*  : dispatch valid/ready handshake and instruction payload
//            cdb_*   : result broadcast buses, bus k at [k*W +: W]
//            iss_*   : per-FU issue valid/ready handshake and payload
//            count   : number of occupied entries
// Options  : `define RS_AGE_SELECT_EN selects the oldest eligible entry per FU
//            (8-bit saturating age); otherwise the lowest-index entry wins.
// Revision : 1.0 - initial release
// ============================================================================
module rs_issue_queue #(
    parameter int RS_DEPTH = 64,
    parameter int PREG_W   = 6,
    parameter int DATA_W   = 32,
    parameter int ROB_W    = 6,
    parameter int NUM_FU   = 3,
    parameter int NUM_CDB  = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        disp_valid,
    output logic                        disp_ready,
    input  logic [3:0]                  disp_alu_ctrl,
    input  logic                        disp_alusrc,
    input  logic [PREG_W-1:0]           disp_prd,
    input  logic [PREG_W-1:0]           disp_prs1,
    input  logic [PREG_W-1:0]           disp_prs2,
    input  logic                        disp_rs1_rdy,
    input  logic                        disp_rs2_rdy,
    input  logic [DATA_W-1:0]           disp_rs1_val,
    input  logic [DATA_W-1:0]           disp_rs2_val,
    input  logic [DATA_W-1:0]           disp_imm,
    input  logic [ROB_W-1:0]            disp_rob,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*PREG_W-1:0]   cdb_preg,
    input  logic [NUM_CDB*DATA_W-1:0]   cdb_val,
    output logic [NUM_FU-1:0]           iss_valid,
    input  logic [NUM_FU-1:0]           iss_ready,
    output logic [NUM_FU*4-1:0]         iss_alu_ctrl,
    output logic [NUM_FU*DATA_W-1:0]    iss_op1,
    output logic [NUM_FU*DATA_W-1:0]    iss_op2,
    output logic [NUM_FU*PREG_W-1:0]    iss_prd,
    output logic [NUM_FU*ROB_W-1:0]     iss_rob,
    output logic [$clog2(RS_DEPTH):0]   count
);

    localparam int c_IDX_W = $clog2(RS_DEPTH);
    localparam int c_CNT_W = c_IDX_W + 1;
    localparam int c_FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    logic [RS_DEPTH-1:0] r_valid;
    logic [RS_DEPTH-1:0] r_alusrc;
    logic [RS_DEPTH-1:0] r_rdy1;
    logic [RS_DEPTH-1:0] r_rdy2;
    logic [3:0]          r_alu_ctrl [RS_DEPTH];
    logic [PREG_W-1:0]   r_prd      [RS_DEPTH];
    logic [PREG_W-1:0]   r_prs1     [RS_DEPTH];
    logic [PREG_W-1:0]   r_prs2     [RS_DEPTH];
    logic [DATA_W-1:0]   r_val1     [RS_DEPTH];
    logic [DATA_W-1:0]   r_val2     [RS_DEPTH];
    logic [DATA_W-1:0]   r_imm      [RS_DEPTH];
    logic [c_FU_W-1:0]   r_fu       [RS_DEPTH];
    logic [ROB_W-1:0]    r_rob      [RS_DEPTH];
`ifdef RS_AGE_SELECT_EN
    logic [7:0]          r_age      [RS_DEPTH];
    logic [7:0]          v_best_age;
`endif

    logic [c_CNT_W-1:0]  r_count;
    logic [c_FU_W-1:0]   r_rr;
    // Once an FU sees valid without ready, its selection is pinned so the
    // payload cannot change under a stalled handshake.
    logic [NUM_FU-1:0]   r_lock_vld;
    logic [c_IDX_W-1:0]  r_lock_idx [NUM_FU];

    logic                w_fire;
    logic                w_alloc_found;
    logic [c_IDX_W-1:0]  w_alloc_idx;
    logic [RS_DEPTH-1:0] w_alloc_oh;
    logic [RS_DEPTH-1:0] w_elig;
    logic [NUM_FU-1:0]   w_sel_found;
    logic [c_IDX_W-1:0]  w_sel_idx  [NUM_FU];
    logic [RS_DEPTH-1:0] w_iss_clr;
    logic [c_CNT_W-1:0]  w_iss_cnt;
    logic [DATA_W:0]     w_wk1 [RS_DEPTH];
    logic [DATA_W:0]     w_wk2 [RS_DEPTH];
    logic [DATA_W:0]     w_dsp1;
    logic [DATA_W:0]     w_dsp2;

    // Returns {hit, value}; scanning from the top down lets the lowest bus win.
    function automatic logic [DATA_W:0] cdb_lookup(
        input logic [PREG_W-1:0]         tag,
        input logic [NUM_CDB-1:0]        vld,
        input logic [NUM_CDB*PREG_W-1:0] pregs,
        input logic [NUM_CDB*DATA_W-1:0] vals
    );
        logic [DATA_W:0] v_res;
        v_res = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (vld[k] && (pregs[k*PREG_W +: PREG_W] == tag)) begin
                v_res = {1'b1, vals[k*DATA_W +: DATA_W]};
            end
        end
        return v_res;
    endfunction

    // ------------------------------------------------------------------
    // Dispatch handshake and free-slot search
    // ------------------------------------------------------------------
    assign disp_ready = (r_count < c_CNT_W'(RS_DEPTH));
    assign count      = r_count;

    always_comb begin
        w_alloc_found = 1'b0;
        w_alloc_idx   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!r_valid[i] && !w_alloc_found) begin
                w_alloc_found = 1'b1;
                w_alloc_idx   = c_IDX_W'(i);
            end
        end
    end

    assign w_fire     = disp_valid && disp_ready && w_alloc_found;
    assign w_alloc_oh = {{(RS_DEPTH-1){1'b0}}, 1'b1} << w_alloc_idx;

    // ------------------------------------------------------------------
    // Wakeup matches for stored entries and the incoming instruction
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_wk1[i] = cdb_lookup(r_prs1[i], cdb_valid, cdb_preg, cdb_val);
            w_wk2[i] = cdb_lookup(r_prs2[i], cdb_valid, cdb_preg, cdb_val);
        end
    end

    assign w_dsp1 = cdb_lookup(disp_prs1, cdb_valid, cdb_preg, cdb_val);
    assign w_dsp2 = cdb_lookup(disp_prs2, cdb_valid, cdb_preg, cdb_val);

    // ------------------------------------------------------------------
    // Issue select (stored state only, so wakeups issue one cycle later)
    // ------------------------------------------------------------------
    assign w_elig = r_valid & r_rdy1 & (r_rdy2 | r_alusrc);

    always_comb begin
        w_sel_found = '0;
`ifdef RS_AGE_SELECT_EN
        v_best_age  = '0;
`endif
        for (int f = 0; f < NUM_FU; f++) begin
            w_sel_idx[f] = '0;
`ifdef RS_AGE_SELECT_EN
            v_best_age   = '0;
`endif
            if (r_lock_vld[f]) begin
                w_sel_found[f] = 1'b1;
                w_sel_idx[f]   = r_lock_idx[f];
            end else begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (w_elig[i] && (r_fu[i] == c_FU_W'(f))) begin
`ifdef RS_AGE_SELECT_EN
                        // Strictly greater keeps ties on the lowest index.
                        if (!w_sel_found[f] || (r_age[i] > v_best_age)) begin
                            w_sel_found[f] = 1'b1;
                            w_sel_idx[f]   = c_IDX_W'(i);
                            v_best_age     = r_age[i];
                        end
`else
                        if (!w_sel_found[f]) begin
                            w_sel_found[f] = 1'b1;
                            w_sel_idx[f]   = c_IDX_W'(i);
                        end
`endif
                    end
                end
            end
        end
    end

    always_comb begin
        iss_valid    = '0;
        iss_alu_ctrl = '0;
        iss_op1      = '0;
        iss_op2      = '0;
        iss_prd      = '0;
        iss_rob      = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            if (w_sel_found[f]) begin
                iss_valid[f]                    = 1'b1;
                iss_alu_ctrl[f*4 +: 4]          = r_alu_ctrl[w_sel_idx[f]];
                iss_op1[f*DATA_W +: DATA_W]     = r_val1[w_sel_idx[f]];
                iss_op2[f*DATA_W +: DATA_W]     = r_alusrc[w_sel_idx[f]] ? r_imm[w_sel_idx[f]]
                                                                         : r_val2[w_sel_idx[f]];
                iss_prd[f*PREG_W +: PREG_W]     = r_prd[w_sel_idx[f]];
                iss_rob[f*ROB_W +: ROB_W]       = r_rob[w_sel_idx[f]];
            end
        end
    end

    always_comb begin
        w_iss_clr = '0;
        w_iss_cnt = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            if (w_sel_found[f] && iss_ready[f]) begin
                w_iss_clr[w_sel_idx[f]] = 1'b1;
                w_iss_cnt               = w_iss_cnt + c_CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Control state: valid bits, occupancy, round-robin, select locks
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid    <= '0;
            r_count    <= '0;
            r_rr       <= '0;
            r_lock_vld <= '0;
            for (int f = 0; f < NUM_FU; f++) r_lock_idx[f] <= '0;
        end else if (flush) begin
            r_valid    <= '0;
            r_count    <= '0;
            r_rr       <= '0;
            r_lock_vld <= '0;
            for (int f = 0; f < NUM_FU; f++) r_lock_idx[f] <= '0;
        end else begin
            r_valid <= (r_valid & ~w_iss_clr) | (w_fire ? w_alloc_oh : '0);
            r_count <= r_count + c_CNT_W'(w_fire) - w_iss_cnt;
            if (w_fire) begin
                r_rr <= (r_rr == c_FU_W'(NUM_FU - 1)) ? '0 : r_rr + c_FU_W'(1);
            end
            for (int f = 0; f < NUM_FU; f++) begin
                r_lock_vld[f] <= w_sel_found[f] && !iss_ready[f];
                r_lock_idx[f] <= w_sel_idx[f];
            end
        end
    end

    // ------------------------------------------------------------------
    // Entry payload: dispatch write (with same-cycle bypass) or wakeup.
    // Payload of invalid entries is don't-care, so it carries no reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (w_fire && (w_alloc_idx == c_IDX_W'(i))) begin
                r_alu_ctrl[i] <= disp_alu_ctrl;
                r_alusrc[i]   <= disp_alusrc;
                r_prd[i]      <= disp_prd;
                r_prs1[i]     <= disp_prs1;
                r_prs2[i]     <= disp_prs2;
                r_rdy1[i]     <= disp_rs1_rdy | w_dsp1[DATA_W];
                r_rdy2[i]     <= disp_rs2_rdy | w_dsp2[DATA_W];
                r_val1[i]     <= (!disp_rs1_rdy && w_dsp1[DATA_W]) ? w_dsp1[DATA_W-1:0] : disp_rs1_val;
                r_val2[i]     <= (!disp_rs2_rdy && w_dsp2[DATA_W]) ? w_dsp2[DATA_W-1:0] : disp_rs2_val;
                r_imm[i]      <= disp_imm;
                r_fu[i]       <= r_rr;
                r_rob[i]      <= disp_rob;
`ifdef RS_AGE_SELECT_EN
                r_age[i]      <= '0;
`endif
            end else begin
                if (r_valid[i] && !r_rdy1[i] && w_wk1[i][DATA_W]) begin
                    r_rdy1[i] <= 1'b1;
                    r_val1[i] <= w_wk1[i][DATA_W-1:0];
                end
                if (r_valid[i] && !r_rdy2[i] && w_wk2[i][DATA_W]) begin
                    r_rdy2[i] <= 1'b1;
                    r_val2[i] <= w_wk2[i][DATA_W-1:0];
                end
`ifdef RS_AGE_SELECT_EN
                if (r_valid[i] && (r_age[i] != 8'hFF)) begin
                    r_age[i] <= r_age[i] + 8'd1;
                end
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rs_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_issue_queue
// Purpose  : Self-checking bench for rs_issue_queue (default build). Expected
//            issues are pushed to a scoreboard at dispatch and matched by ROB
//            index when the DUT fires an issue handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs_issue_queue;

    localparam int RS_DEPTH = 64;
    localparam int PREG_W   = 6;
    localparam int DATA_W   = 32;
    localparam int ROB_W    = 6;
    localparam int NUM_FU   = 3;
    localparam int NUM_CDB  = 2;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       flush;
    logic                       disp_valid;
    logic                       disp_ready;
    logic [3:0]                 disp_alu_ctrl;
    logic                       disp_alusrc;
    logic [PREG_W-1:0]          disp_prd, disp_prs1, disp_prs2;
    logic                       disp_rs1_rdy, disp_rs2_rdy;
    logic [DATA_W-1:0]          disp_rs1_val, disp_rs2_val, disp_imm;
    logic [ROB_W-1:0]           disp_rob;
    logic [NUM_CDB-1:0]         cdb_valid;
    logic [NUM_CDB*PREG_W-1:0]  cdb_preg;
    logic [NUM_CDB*DATA_W-1:0]  cdb_val;
    logic [NUM_FU-1:0]          iss_valid;
    logic [NUM_FU-1:0]          iss_ready;
    logic [NUM_FU*4-1:0]        iss_alu_ctrl;
    logic [NUM_FU*DATA_W-1:0]   iss_op1, iss_op2;
    logic [NUM_FU*PREG_W-1:0]   iss_prd;
    logic [NUM_FU*ROB_W-1:0]    iss_rob;
    logic [$clog2(RS_DEPTH):0]  count;

    rs_issue_queue #(
        .RS_DEPTH(RS_DEPTH), .PREG_W(PREG_W), .DATA_W(DATA_W),
        .ROB_W(ROB_W), .NUM_FU(NUM_FU), .NUM_CDB(NUM_CDB)
    ) u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_alu_ctrl(disp_alu_ctrl), .disp_alusrc(disp_alusrc),
        .disp_prd(disp_prd), .disp_prs1(disp_prs1), .disp_prs2(disp_prs2),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
        .disp_rs1_val(disp_rs1_val), .disp_rs2_val(disp_rs2_val),
        .disp_imm(disp_imm), .disp_rob(disp_rob),
        .cdb_valid(cdb_valid), .cdb_preg(cdb_preg), .cdb_val(cdb_val),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_alu_ctrl(iss_alu_ctrl), .iss_op1(iss_op1), .iss_op2(iss_op2),
        .iss_prd(iss_prd), .iss_rob(iss_rob), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]        fu;
        logic [3:0]        alu;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [PREG_W-1:0] prd;
        logic [ROB_W-1:0]  rob;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   tb_rr = 0;
    int   seq   = 0;

    // Scoreboard: every fired issue must match an outstanding expectation.
    always @(negedge clk) begin
        if (!reset) begin
            for (int f = 0; f < NUM_FU; f++) begin
                if (iss_valid[f] && iss_ready[f]) begin
                    int   hit;
                    exp_t e;
                    exp_t g;
                    hit = -1;
                    for (int j = 0; j < sb.size(); j++) begin
                        if (hit < 0 && sb[j].rob == iss_rob[f*ROB_W +: ROB_W]) hit = j;
                    end
                    g.fu  = 2'(f);
                    g.alu = iss_alu_ctrl[f*4 +: 4];
                    g.op1 = iss_op1[f*DATA_W +: DATA_W];
                    g.op2 = iss_op2[f*DATA_W +: DATA_W];
                    g.prd = iss_prd[f*PREG_W +: PREG_W];
                    g.rob = iss_rob[f*ROB_W +: ROB_W];
                    n_cmp++;
                    if (hit < 0) begin
                        n_err++;
                        $display("FAIL sb_issue: got unexpected issue fu=%0d rob=%0d, required none", f, g.rob);
                    end else begin
                        e = sb[hit];
                        if (g !== e) begin
                            n_err++;
                            $display("FAIL sb_payload: got fu=%0d alu=%h op1=%h op2=%h prd=%0d rob=%0d, required fu=%0d alu=%h op1=%h op2=%h prd=%0d rob=%0d",
                                     g.fu, g.alu, g.op1, g.op2, g.prd, g.rob,
                                     e.fu, e.alu, e.op1, e.op2, e.prd, e.rob);
                        end
                        sb.delete(hit);
                    end
                end
            end
        end
    end

    // Drives one dispatch cycle (entered/left at posedge+1); pushes the
    // expected issue when the handshake fires.
    task automatic dispatch(input logic [3:0] alu, input logic alusrc,
                            input logic [PREG_W-1:0] prd, input logic [PREG_W-1:0] p1,
                            input logic [PREG_W-1:0] p2, input logic r1, input logic r2,
                            input logic [DATA_W-1:0] v1, input logic [DATA_W-1:0] v2,
                            input logic [DATA_W-1:0] imm, input logic [DATA_W-1:0] e1,
                            input logic [DATA_W-1:0] e2, output bit fired);
        exp_t e;
        disp_valid = 1'b1; disp_alu_ctrl = alu; disp_alusrc = alusrc;
        disp_prd = prd; disp_prs1 = p1; disp_prs2 = p2;
        disp_rs1_rdy = r1; disp_rs2_rdy = r2;
        disp_rs1_val = v1; disp_rs2_val = v2; disp_imm = imm;
        disp_rob = ROB_W'(seq);
        @(negedge clk);
        fired = disp_ready;
        if (fired) begin
            e.fu = 2'(tb_rr); e.alu = alu; e.op1 = e1;
            e.op2 = alusrc ? imm : e2; e.prd = prd; e.rob = ROB_W'(seq);
            sb.push_back(e);
            seq++;
            tb_rr = (tb_rr == NUM_FU - 1) ? 0 : tb_rr + 1;
        end
        @(posedge clk); #1;
        disp_valid = 1'b0;
    endtask

    task automatic disp_rdy(input int k, output bit fired);
        dispatch(4'(k), 1'b0, PREG_W'(k), PREG_W'(k + 1), PREG_W'(k + 2), 1'b1, 1'b1,
                 DATA_W'(k), DATA_W'(k * 3 + 1), '0, DATA_W'(k), DATA_W'(k * 3 + 1), fired);
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++; if (disp_ready !== 1'b1) begin n_err++; $display("FAIL reset_disp_ready: got %b required 1", disp_ready); end
        n_cmp++; if (iss_valid !== 3'b000) begin n_err++; $display("FAIL reset_iss_valid: got %b required 000", iss_valid); end
        n_cmp++; if (count !== 7'd0) begin n_err++; $display("FAIL reset_count: got %0d required 0", count); end
        n_cmp++;
        if ({iss_alu_ctrl, iss_op1, iss_op2, iss_prd, iss_rob} !== '0) begin
            n_err++; $display("FAIL reset_payload: got op1=%h op2=%h required all zero", iss_op1, iss_op2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        bit f;
        iss_ready = 3'b111;
        dispatch(4'h0, 1'b0, 6'd3, 6'd5, 6'd7, 1'b1, 1'b1, 32'd3, 32'd4, '0, 32'd3, 32'd4, f);
        @(negedge clk);
        n_cmp++; if (iss_valid !== 3'b001) begin n_err++; $display("FAIL basic_iss_valid: got %b required 001", iss_valid); end
        n_cmp++; if (iss_op1[31:0] !== 32'd3 || iss_op2[31:0] !== 32'd4) begin
            n_err++; $display("FAIL basic_ops: got op1=%h op2=%h required 3/4", iss_op1[31:0], iss_op2[31:0]);
        end
        @(posedge clk); #1;
        n_cmp++; if (count !== 7'd0) begin n_err++; $display("FAIL basic_count: got %0d required 0", count); end
    endtask

    task automatic test_wakeup;
        bit f;
        dispatch(4'h1, 1'b0, 6'd10, 6'd8, 6'd9, 1'b1, 1'b0, 32'h11, 32'h0, '0, 32'h11, 32'h55, f);
        @(negedge clk);
        n_cmp++; if (iss_valid !== 3'b000) begin n_err++; $display("FAIL wake_early0: got %b required 000", iss_valid); end
        @(posedge clk); #1;
        cdb_valid = 2'b10; cdb_preg = {6'd9, 6'd0}; cdb_val = {32'h55, 32'h0};
        @(negedge clk);
        n_cmp++; if (iss_valid !== 3'b000) begin n_err++; $display("FAIL wake_early1: got %b required 000", iss_valid); end
        @(posedge clk); #1;
        cdb_valid = 2'b00;
        @(negedge clk);
        n_cmp++; if (iss_valid !== 3'b010) begin n_err++; $display("FAIL wake_iss_valid: got %b required 010", iss_valid); end
        n_cmp++; if (iss_op2[32 +: 32] !== 32'h55) begin n_err++; $display("FAIL wake_op2: got %h required 55", iss_op2[32 +: 32]); end
        @(posedge clk); #1;
    endtask

    task automatic test_bypass;
        bit f;
        // Both buses carry tag 12; bus 0 must win.
        cdb_valid = 2'b11; cdb_preg = {6'd12, 6'd12}; cdb_val = {32'hBB, 32'hAA};
        dispatch(4'h2, 1'b0, 6'd20, 6'd12, 6'd13, 1'b0, 1'b1, 32'h0, 32'h7, '0, 32'hAA, 32'h7, f);
        cdb_valid = 2'b00;
        @(negedge clk);
        n_cmp++; if (iss_valid !== 3'b100) begin n_err++; $display("FAIL bypass_iss_valid: got %b required 100", iss_valid); end
        n_cmp++; if (iss_op1[64 +: 32] !== 32'hAA) begin n_err++; $display("FAIL bypass_op1: got %h required aa", iss_op1[64 +: 32]); end
        @(posedge clk); #1;
    endtask

    task automatic test_full;
        bit f;
        int nf;
        iss_ready = 3'b000;
        nf = 0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            disp_rdy(i, f);
            if (f) nf++;
        end
        n_cmp++; if (nf != RS_DEPTH) begin n_err++; $display("FAIL full_accepted: got %0d required %0d", nf, RS_DEPTH); end
        n_cmp++; if (count !== 7'd64 || disp_ready !== 1'b0) begin
            n_err++; $display("FAIL full_state: got count=%0d ready=%b required 64/0", count, disp_ready);
        end
        disp_rdy(99, f);
        n_cmp++; if (f !== 1'b0 || count !== 7'd64) begin
            n_err++; $display("FAIL full_extra: got fired=%b count=%0d required 0/64", f, count);
        end
        iss_ready = 3'b001;
        @(posedge clk); #1;
        iss_ready = 3'b000;
        n_cmp++; if (count !== 7'd63 || disp_ready !== 1'b1) begin
            n_err++; $display("FAIL full_pop: got count=%0d ready=%b required 63/1", count, disp_ready);
        end
        iss_ready = 3'b111;
        for (int c = 0; c < 200 && count != 0; c++) begin @(posedge clk); #1; end
        n_cmp++; if (count !== 7'd0 || sb.size() != 0) begin
            n_err++; $display("FAIL full_drain: got count=%0d pending=%0d required 0/0", count, sb.size());
        end
    endtask

    task automatic test_flush;
        bit f;
        iss_ready = 3'b000;
        for (int i = 0; i < 10; i++) disp_rdy(i + 1, f);
        n_cmp++; if (count !== 7'd10) begin n_err++; $display("FAIL flush_pre_count: got %0d required 10", count); end
        // A dispatch in the flush cycle must be discarded too.
        flush = 1'b1; disp_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; disp_valid = 1'b0;
        sb.delete(); tb_rr = 0;
        n_cmp++; if (count !== 7'd0) begin n_err++; $display("FAIL flush_count: got %0d required 0", count); end
        @(negedge clk);
        n_cmp++; if (iss_valid !== 3'b000) begin n_err++; $display("FAIL flush_iss_valid: got %b required 000", iss_valid); end
        @(posedge clk); #1;
        iss_ready = 3'b111;
        disp_rdy(40, f);
        @(negedge clk);
        n_cmp++; if (iss_valid !== 3'b001) begin n_err++; $display("FAIL flush_rr_restart: got %b required 001", iss_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        bit f;
        int base;
        logic [NUM_FU*(2*DATA_W+PREG_W+ROB_W+4)-1:0] snap;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; tb_rr = 0;
        iss_ready = 3'b000;
        base = seq;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) dispatch(4'h9, 1'b1, 6'd50, 6'd51, 6'd52, 1'b1, 1'b0,
                                 32'hC0DE, 32'h0, 32'h1234, 32'hC0DE, 32'h0, f);
            else disp_rdy(i + 60, f);
        end
        @(negedge clk);
        n_cmp++; if (iss_valid !== 3'b111) begin n_err++; $display("FAIL rr_iss_valid: got %b required 111", iss_valid); end
        n_cmp++;
        if (iss_rob !== {ROB_W'(base + 2), ROB_W'(base + 1), ROB_W'(base)}) begin
            n_err++; $display("FAIL rr_first_three: got rob=%h required %0d,%0d,%0d", iss_rob, base, base + 1, base + 2);
        end
        snap = {iss_alu_ctrl, iss_op1, iss_op2, iss_prd, iss_rob};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (iss_valid !== 3'b111 || {iss_alu_ctrl, iss_op1, iss_op2, iss_prd, iss_rob} !== snap) begin
                n_err++; $display("FAIL rr_stable: got valid=%b rob=%h required 111 rob=%h", iss_valid, iss_rob, snap[NUM_FU*ROB_W-1:0]);
            end
        end
        @(posedge clk); #1;
        iss_ready = 3'b111;
        for (int c = 0; c < 50 && count != 0; c++) begin @(posedge clk); #1; end
        n_cmp++; if (count !== 7'd0 || sb.size() != 0) begin
            n_err++; $display("FAIL rr_drain: got count=%0d pending=%0d required 0/0", count, sb.size());
        end
    endtask

    task automatic test_async_reset;
        bit f;
        iss_ready = 3'b000;
        disp_rdy(70, f);
        disp_rdy(71, f);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (count !== 7'd0 || iss_valid !== 3'b000 || disp_ready !== 1'b1) begin
            n_err++; $display("FAIL async_reset: got count=%0d valid=%b ready=%b required 0/000/1", count, iss_valid, disp_ready);
        end
        sb.delete(); tb_rr = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (count !== 7'd0) begin n_err++; $display("FAIL async_reset_hold: got %0d required 0", count); end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; disp_valid = 1'b0;
        disp_alu_ctrl = '0; disp_alusrc = 1'b0;
        disp_prd = '0; disp_prs1 = '0; disp_prs2 = '0;
        disp_rs1_rdy = 1'b0; disp_rs2_rdy = 1'b0;
        disp_rs1_val = '0; disp_rs2_val = '0; disp_imm = '0; disp_rob = '0;
        cdb_valid = '0; cdb_preg = '0; cdb_val = '0;
        iss_ready = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        test_reset();
        test_basic();
        test_wakeup();
        test_bypass();
        test_full();
        test_flush();
        test_back_to_back();
        test_async_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rs_issue_queue.md
Name: rs_issue_queue

Overview:
Parametrised reservation station and issue queue between dispatch/rename and the ALU functional units (FUs). It accepts one renamed instruction per cycle through a valid/ready handshake and assigns it an FU round-robin. It captures results broadcast on NUM_CDB result buses to wake waiting operands. Each cycle it issues at most one fully ready entry per FU, then frees that entry.

Parameters:
RS_DEPTH, 64, number of entries (power of 2, >=4)
PREG_W, 6, physical register tag width
DATA_W, 32, operand width
ROB_W, 6, ROB index width
NUM_FU, 3, number of issue ports / FUs (1..4)
NUM_CDB, 2, number of result broadcast buses

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of all entries
disp_valid  in  1  dispatch request
disp_ready  out  1  queue can accept this cycle
disp_alu_ctrl  in  4  ALU operation
disp_alusrc  in  1  1 = operand 2 is disp_imm
disp_prd, disp_prs1, disp_prs2  in  PREG_W each  dest/source tags
disp_rs1_rdy, disp_rs2_rdy  in  1 each  source value already valid
disp_rs1_val, disp_rs2_val  in  DATA_W each  source values
disp_imm  in  DATA_W  immediate
disp_rob  in  ROB_W  ROB index
cdb_valid  in  NUM_CDB  broadcast valid per bus
cdb_preg  in  NUM_CDB*PREG_W  broadcast tags, bus k at [k*PREG_W +: PREG_W]
cdb_val  in  NUM_CDB*DATA_W  broadcast values
iss_valid  out  NUM_FU  issue valid per FU
iss_ready  in  NUM_FU  FU accepts
iss_alu_ctrl  out  NUM_FU*4  per-FU op
iss_op1, iss_op2  out  NUM_FU*DATA_W each  operands (op2 = imm when alusrc)
iss_prd  out  NUM_FU*PREG_W  dest tag
iss_rob  out  NUM_FU*ROB_W  ROB index
count  out  $clog2(RS_DEPTH)+1  occupied entries

Behaviour:
- Reset (async) and flush (sync, priority over all other events): all entries invalid; count=0; round-robin pointer=0. Outputs after reset: disp_ready=1, iss_valid=0, all other iss_* = 0.
- Entry fields: valid, alu_ctrl, alusrc, prd, prs1/rdy1/val1, prs2/rdy2/val2, imm, fu, rob.
- disp_ready = (count < RS_DEPTH), combinational. An entry freed by issue in the same cycle does not raise disp_ready.
- Dispatch fires on disp_valid && disp_ready. The entry is written at the clock edge into the lowest-index invalid slot, with fu = rr pointer.
- rr pointer advances only on a fired dispatch: 0,1,...,NUM_FU-1, then wraps to 0.
- Wakeup: for each valid entry and each bus k, if cdb_valid[k] and the source is not ready and its tag == cdb_preg[k], set rdy=1 and val=cdb_val bus k at the edge.
  - Several buses matching the same source: the lowest k wins.
  - Dispatch bypass: a dispatched source with rdy=0 whose tag matches an active bus in the same cycle is written ready with that bus value.
- Issue eligibility for FU f: entry valid, fu==f, rdy1=1, and (rdy2=1 or alusrc=1).
  - Eligibility uses stored state only, so a wakeup at edge t allows issue in the cycle after t.
  - The earliest cycle iss_valid can rise is the cycle after the dispatch edge.
- Select: lowest-index eligible entry per FU, unless RS_AGE_SELECT_EN is defined. iss_* outputs are combinational from the selected entry.
  - iss_valid[f]=1 holds with stable payload until iss_ready[f]=1.
- On iss_valid[f] && iss_ready[f], the selected entry is invalidated at the edge. Multiple FUs may issue in one cycle.
- count next = count + fired dispatch − number of issues fired. Count never exceeds RS_DEPTH and never underflows.
- Full queue (count==RS_DEPTH): disp_ready=0 and disp_valid is ignored. Issues still proceed.
- Empty queue: iss_valid all 0.
- Reset asserted mid-operation discards all entries immediately. No partial state survives.

Optional Feature:
RS_AGE_SELECT_EN
- Defined:
  - Each entry carries an 8-bit age: cleared on dispatch, incremented each cycle while valid, saturating at 255.
  - Per-FU select picks the eligible entry with the largest age; ties go to the lowest index.
- Not defined: no age storage; lowest-index select.

Test Plan:
- Dispatch ADD, prs1=5 rdy, prs2=7 rdy, values 3 and 4, iss_ready all 1 -> next cycle iss_valid[0]=1, iss_op1=3, iss_op2=4; count returns to 0.
- Dispatch with prs2=9 not ready; cdb_valid[1]=1, cdb_preg=9, cdb_val=0x55 two cycles later -> iss_valid rises the cycle after the broadcast with iss_op2=0x55.
- Dispatch with prs1=12 not ready in the same cycle as a bus-0 broadcast of tag 12 value 0xAA -> entry issues the next cycle with op1=0xAA.
- Hold iss_ready=0 and dispatch RS_DEPTH instructions -> count=RS_DEPTH, disp_ready=0; extra disp_valid ignored. Raise iss_ready[0] for one cycle -> count=RS_DEPTH−1, disp_ready=1 next cycle.
- Dispatch 6 ready instructions with NUM_FU=3 -> fu assignment 0,1,2,0,1,2; iss_valid=3'b111 while iss_ready is held 0, with payloads stable.
- Assert flush with 10 entries queued -> next cycle count=0, iss_valid=0, and the next dispatch is assigned fu=0.
